echo_selftest: RTL and testbench
================================

Name: echo_selftest

Overview:
Synthesizable, parametrised self-test sequencer for the UART echo path. On start it waits a programmable settle period, then sends NUM_WORDS patterned words one at a time over a valid/ready TX interface. After each word it waits, with a timeout, for the echoed word on the RX strobe interface and compares it against the expected value. It reports done, pass and error/progress counters, so the same block serves as the simulation bench driver and as an on-board loopback checker.

Parameters:
DATA_W, 8, word width in bits.
NUM_WORDS, 16, words per run (>=1).
WAIT_CYCLES, 10, settle cycles between start and first send (>=0).
TIMEOUT, 1023, max cycles in RECV before a word is declared lost (>=1).
SEED, 8'h41, first pattern value (truncated/zero-extended to DATA_W).
MODE, 0, pattern mode: 0 = increment, 1 = rotate-left.

Ports:
clk  in  1  clock.
rst  in  1  synchronous active-high reset.
start  in  1  one-cycle pulse; starts a run, honoured only in IDLE or DONE.
tx_data  out  DATA_W  word to transmit.
tx_valid  out  1  tx_data valid.
tx_ready  in  1  sink accepts tx_data this cycle when tx_valid=1.
rx_data  in  DATA_W  echoed word.
rx_valid  in  1  one-cycle strobe, rx_data valid.
busy  out  1  high in WAIT/SEND/RECV.
done  out  1  high in DONE.
pass  out  1  valid while done=1; 1 iff err_count==0.
err_count  out  CW  errors this run, saturating; CW=$clog2(NUM_WORDS+2)+1.
word_count  out  CW  words completed (matched, mismatched or timed out).

Behaviour:
- Reset (rst=1 at posedge, any state): state=IDLE, tx_valid=0, tx_data=0, busy=0, done=0, pass=0, err_count=0, word_count=0, all internal counters=0. rst overrides start.
- FSM states: IDLE, WAIT, SEND, RECV, DONE.
- IDLE: start -> clear err_count, word_count and pattern=SEED. Go to WAIT, or directly to SEND if WAIT_CYCLES=0.
- WAIT: count exactly WAIT_CYCLES cycles, then go to SEND. Rising edges of tx_valid occur exactly WAIT_CYCLES+1 cycles after the start cycle.
- SEND: tx_valid=1 and tx_data=pattern, both registered and held stable until tx_ready. On tx_valid&tx_ready: latch expected=pattern, clear the timeout counter, drop tx_valid the next cycle, go to RECV. Stalls indefinitely without tx_ready; no timeout in SEND.
- RECV: the timeout counter increments each cycle.
  - rx_valid=1: if rx_data!=expected, err_count++. word_count++.
  - Counter reaches TIMEOUT with no rx_valid: err_count++, word_count++.
  - rx_valid on the same cycle as expiry counts as a received word, not a timeout.
  - After either event: advance pattern. If word_count (new value)==NUM_WORDS go to DONE, else go to SEND.
- Pattern advance: MODE 0 -> pattern+1 mod 2^DATA_W (wraps, e.g. 8'hFF->8'h00). MODE 1 -> rotate left by 1.
- rx_valid outside RECV (IDLE, WAIT, SEND, DONE): stray word. err_count++ if busy; ignored in IDLE/DONE.
- err_count saturates at all-ones; never wraps.
- DONE: done=1, pass=(err_count==0), counters hold. start -> same as from IDLE (new run); done/pass drop the cycle after start.
- start while busy: ignored.
- Latency to done: done rises the cycle after the final word's RECV event.

Test Plan:
- Ideal loopback (tx_ready=1, rx_data=tx_data echoed 3 cycles after accept), defaults -> tx_valid first high 11 cycles after start; 16 words 8'h41..8'h50; done=1, pass=1, err_count=0, word_count=16.
- Echo returns 8'h00 for word index 5 only -> done, pass=0, err_count=1, word_count=16.
- Echo never returns, TIMEOUT=7, NUM_WORDS=3 -> each word retires after 7 RECV cycles; err_count=3, pass=0; rx_valid on the expiry cycle of word 2 counts as received (err_count=2).
- tx_ready held low 20 cycles on word 0 -> tx_valid and tx_data=8'h41 stay stable for all 20 cycles; no error counted; run completes normally.
- MODE=1, SEED=8'h81, NUM_WORDS=3 -> tx_data sequence 8'h81, 8'h03, 8'h06. MODE=0, SEED=8'hFE -> 8'hFE, 8'hFF, 8'h00.
- rst asserted mid-RECV, then start again -> all outputs return to reset values the next cycle; rerun passes. Stray rx_valid in WAIT -> err_count=1. start while busy has no effect.

Source files
------------

// File: rtl/echo_selftest.sv
// echo_selftest
//   Self-test sequencer for the UART echo path. After start it waits a settle
//   period and then sends NUM_WORDS patterned words, one at a time, on a
//   valid/ready TX port. After each word it waits, with a timeout, for the
//   echo on the RX strobe port and compares it with the word that was sent.
//   The block can drive a simulation bench or check an on-board loopback.
//
// Ports
//   clk           clock
//   rst           synchronous active-high reset, overrides i_start
//   i_start       one-cycle run request, honoured only in IDLE or DONE
//   o_tx_data     word being offered, registered
//   o_tx_valid    o_tx_data valid, registered, held until i_tx_ready
//   i_tx_ready    sink takes o_tx_data this cycle when o_tx_valid=1
//   i_rx_data     echoed word
//   i_rx_valid    one-cycle strobe qualifying i_rx_data
//   o_busy        run in progress (WAIT/SEND/RECV)
//   o_done        run finished (DONE)
//   o_pass        valid while o_done; 1 when no errors were counted
//   o_err_count   errors this run, saturating
//   o_word_count  words retired this run (matched, mismatched or lost)
//
// state  | meaning
// IDLE   | out of reset, waiting for start
// WAIT   | settle period before the first word
// SEND   | offering the current pattern on TX
// RECV   | waiting for the echo of the word just sent, with timeout
// DONE   | run finished, counters frozen, waiting for a new start

module echo_selftest #(
  parameter int                DATA_W      = 8,
  parameter int                NUM_WORDS   = 16,
  parameter int                WAIT_CYCLES = 10,
  parameter int                TIMEOUT     = 1023,
  parameter logic [DATA_W-1:0] SEED        = 8'h41,
  parameter int                MODE        = 0
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          i_start,
  output logic [DATA_W-1:0]             o_tx_data,
  output logic                          o_tx_valid,
  input  logic                          i_tx_ready,
  input  logic [DATA_W-1:0]             i_rx_data,
  input  logic                          i_rx_valid,
  output logic                          o_busy,
  output logic                          o_done,
  output logic                          o_pass,
  output logic [$clog2(NUM_WORDS+2):0]  o_err_count,
  output logic [$clog2(NUM_WORDS+2):0]  o_word_count
);

  localparam int CW = $clog2(NUM_WORDS + 2) + 1;
  localparam int WW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam int TW = $clog2(TIMEOUT + 1);

  // The settle counter counts down from WAIT_CYCLES-1 so WAIT lasts exactly
  // WAIT_CYCLES cycles; the timeout counter counts up from 0 so RECV lasts
  // at most TIMEOUT cycles.
  localparam logic [WW-1:0] WAIT_LOAD  = WW'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);
  localparam logic [TW-1:0] TO_LAST    = TW'(TIMEOUT - 1);
  localparam logic [CW-1:0] WORDS_LAST = CW'(NUM_WORDS);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_SEND,
    S_RECV,
    S_DONE
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;

  logic [DATA_W-1:0]   r_pattern;
  logic [DATA_W-1:0]   r_expected;
  logic                r_tx_valid;
  logic [WW-1:0]       r_wait_cnt;
  logic [TW-1:0]       r_to_cnt;
  logic [CW-1:0]       r_err_count;
  logic [CW-1:0]       r_word_count;

  logic                w_start_ok;
  logic                w_accept;
  logic                w_expire;
  logic                w_rx_event;
  logic                w_err_hit;
  logic                w_last;
  logic [CW-1:0]       w_wc_inc;
  logic [DATA_W-1:0]   w_pattern_nxt;

  assign w_start_ok = i_start && ((r_state == S_IDLE) || (r_state == S_DONE));
  assign w_accept   = (r_state == S_SEND) && r_tx_valid && i_tx_ready;
  assign w_expire   = (r_state == S_RECV) && (r_to_cnt == TO_LAST);
  // An echo landing on the expiry cycle is a received word, not a loss.
  assign w_rx_event = (r_state == S_RECV) && (i_rx_valid || w_expire);
  assign w_wc_inc   = r_word_count + 1'b1;
  assign w_last     = (w_wc_inc == WORDS_LAST);

  always_comb begin
    w_err_hit = 1'b0;
    case (r_state)
      S_RECV:         w_err_hit = i_rx_valid ? (i_rx_data != r_expected) : w_expire;
      S_WAIT, S_SEND: w_err_hit = i_rx_valid;
      default:        w_err_hit = 1'b0;
    endcase
  end

  always_comb begin
    w_pattern_nxt = r_pattern + 1'b1;
    if (MODE == 1) begin
      w_pattern_nxt = (r_pattern << 1) | (r_pattern >> (DATA_W - 1));
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE, S_DONE: begin
        if (i_start) begin
          w_state_nxt = (WAIT_CYCLES == 0) ? S_SEND : S_WAIT;
        end
      end
      S_WAIT: begin
        if (r_wait_cnt == '0) begin
          w_state_nxt = S_SEND;
        end
      end
      S_SEND: begin
        if (w_accept) begin
          w_state_nxt = S_RECV;
        end
      end
      S_RECV: begin
        if (w_rx_event) begin
          w_state_nxt = w_last ? S_DONE : S_SEND;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Outputs decoded from state
  always_comb begin
    o_busy = 1'b0;
    o_done = 1'b0;
    o_pass = 1'b0;
    case (r_state)
      S_WAIT, S_SEND, S_RECV: o_busy = 1'b1;
      S_DONE: begin
        o_done = 1'b1;
        o_pass = (r_err_count == '0);
      end
      default: ;
    endcase
  end

  // Datapath: pattern, counters and the registered TX handshake
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pattern    <= '0;
      r_expected   <= '0;
      r_tx_valid   <= 1'b0;
      r_wait_cnt   <= '0;
      r_to_cnt     <= '0;
      r_err_count  <= '0;
      r_word_count <= '0;
    end else begin
      // Valid tracks the state we are entering, so it is high on the first
      // SEND cycle and drops on the cycle after the accept.
      r_tx_valid <= (w_state_nxt == S_SEND);

      if (w_start_ok) begin
        r_err_count  <= '0;
        r_word_count <= '0;
        r_pattern    <= SEED;
        r_wait_cnt   <= WAIT_LOAD;
      end else begin
        if (w_err_hit && !(&r_err_count)) begin
          r_err_count <= r_err_count + 1'b1;
        end

        if ((r_state == S_WAIT) && (r_wait_cnt != '0)) begin
          r_wait_cnt <= r_wait_cnt - 1'b1;
        end

        if (w_accept) begin
          r_expected <= r_pattern;
          r_to_cnt   <= '0;
        end else if (r_state == S_RECV) begin
          r_to_cnt <= r_to_cnt + 1'b1;
        end

        if (w_rx_event) begin
          r_word_count <= w_wc_inc;
          r_pattern    <= w_pattern_nxt;
        end
      end
    end
  end

  assign o_tx_data    = r_pattern;
  assign o_tx_valid   = r_tx_valid;
  assign o_err_count  = r_err_count;
  assign o_word_count = r_word_count;

endmodule

// File: tb/tb_echo_selftest.sv
module tb_echo_selftest;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  // dut0: defaults (16 words, seed 8'h41, increment, settle 10, timeout 1023)
  logic       start0 = 1'b0, ready0 = 1'b0, rxv0 = 1'b0;
  logic [7:0] rxd0 = 8'h00;
  logic [7:0] txd0;
  logic       txv0, busy0, done0, pass0;
  logic [5:0] err0, wc0;

  echo_selftest dut0 (
    .clk(clk), .rst(rst), .i_start(start0),
    .o_tx_data(txd0), .o_tx_valid(txv0), .i_tx_ready(ready0),
    .i_rx_data(rxd0), .i_rx_valid(rxv0),
    .o_busy(busy0), .o_done(done0), .o_pass(pass0),
    .o_err_count(err0), .o_word_count(wc0)
  );

  // dut1: 3 words, timeout 7, settle 2, seed 8'hFE, increment
  logic       start1 = 1'b0, ready1 = 1'b1, rxv1 = 1'b0;
  logic [7:0] rxd1 = 8'h00;
  logic [7:0] txd1;
  logic       txv1, busy1, done1, pass1;
  logic [3:0] err1, wc1;

  echo_selftest #(.NUM_WORDS(3), .WAIT_CYCLES(2), .TIMEOUT(7), .SEED(8'hFE), .MODE(0)) dut1 (
    .clk(clk), .rst(rst), .i_start(start1),
    .o_tx_data(txd1), .o_tx_valid(txv1), .i_tx_ready(ready1),
    .i_rx_data(rxd1), .i_rx_valid(rxv1),
    .o_busy(busy1), .o_done(done1), .o_pass(pass1),
    .o_err_count(err1), .o_word_count(wc1)
  );

  // dut2: 3 words, no settle, timeout 3, seed 8'h81, rotate-left
  logic       start2 = 1'b0, ready2 = 1'b1, rxv2 = 1'b0;
  logic [7:0] rxd2 = 8'h00;
  logic [7:0] txd2;
  logic       txv2, busy2, done2, pass2;
  logic [3:0] err2, wc2;

  echo_selftest #(.NUM_WORDS(3), .WAIT_CYCLES(0), .TIMEOUT(3), .SEED(8'h81), .MODE(1)) dut2 (
    .clk(clk), .rst(rst), .i_start(start2),
    .o_tx_data(txd2), .o_tx_valid(txv2), .i_tx_ready(ready2),
    .i_rx_data(rxd2), .i_rx_valid(rxv2),
    .o_busy(busy2), .o_done(done2), .o_pass(pass2),
    .o_err_count(err2), .o_word_count(wc2)
  );

  // Per-word plan for a dut0 run
  int         stall_q [16];
  int         dly_q   [16];
  bit         drop_q  [16];
  bit         bad_q   [16];
  bit         sb_q    [16];
  logic [7:0] badv_q  [16];

  task automatic clear_plan();
    for (int i = 0; i < 16; i++) begin
      stall_q[i] = 0;
      dly_q[i]   = 3;
      drop_q[i]  = 1'b0;
      bad_q[i]   = 1'b0;
      sb_q[i]    = 1'b0;
      badv_q[i]  = 8'h00;
    end
  endtask

  // One full dut0 run driven from the plan. The expected error count is built
  // from the plan: each lost word, each wrong echo and an optional stray strobe.
  task automatic run0(input string tag, input bit stray_wait);
    int k;
    int exp_err;
    logic [7:0] pat;
    bit lost;
    exp_err = 0;
    lost = 1'b0;
    @(negedge clk); start0 = 1'b1;
    @(negedge clk); start0 = 1'b0;
    k = 1;
    n_vec++;
    if (busy0 !== 1'b1 || done0 !== 1'b0) begin
      n_bad++;
      $display("FAIL %s start_ack: busy=%b done=%b want busy=1 done=0", tag, busy0, done0);
    end
    if (stray_wait) begin
      rxv0 = 1'b1;
      rxd0 = 8'($urandom);
      exp_err++;
    end
    while (txv0 !== 1'b1 && k < 40) begin
      @(negedge clk); rxv0 = 1'b0; k++;
    end
    n_vec++;
    if (k !== 11) begin
      n_bad++;
      $display("FAIL %s first_valid_latency: got %0d cycles want 11", tag, k);
    end
    for (int i = 0; i < 16 && !lost; i++) begin
      pat = 8'(8'h41 + i);
      k = 0;
      while (txv0 !== 1'b1 && k < 2000) begin
        @(negedge clk); k++;
      end
      if (txv0 !== 1'b1) begin
        n_vec++; n_bad++;
        $display("FAIL %s tx_valid_wait word %0d: tx_valid=%b after %0d cycles want 1", tag, i, txv0, k);
        lost = 1'b1;
      end else begin
        for (int j = 0; j < stall_q[i]; j++) begin
          n_vec++;
          if (txv0 !== 1'b1 || txd0 !== pat) begin
            n_bad++;
            $display("FAIL %s stall_hold word %0d cyc %0d: valid=%b data=%h want 1/%h", tag, i, j, txv0, txd0, pat);
          end
          start0 = (j == 0) && sb_q[i];
          @(negedge clk); start0 = 1'b0;
        end
        n_vec++;
        if (txd0 !== pat) begin
          n_bad++;
          $display("FAIL %s tx_data word %0d: got %h want %h", tag, i, txd0, pat);
        end
        ready0 = 1'b1;
        @(negedge clk); ready0 = 1'b0;
        n_vec++;
        if (txv0 !== 1'b0) begin
          n_bad++;
          $display("FAIL %s tx_valid_drop word %0d: got %b want 0", tag, i, txv0);
        end
        if (drop_q[i]) begin
          exp_err++;
        end else begin
          repeat (dly_q[i] - 1) @(negedge clk);
          rxv0 = 1'b1;
          rxd0 = bad_q[i] ? badv_q[i] : pat;
          if (bad_q[i] && badv_q[i] != pat) exp_err++;
          @(negedge clk); rxv0 = 1'b0;
          if (i == 15) begin
            n_vec++;
            if (done0 !== 1'b1) begin
              n_bad++;
              $display("FAIL %s done_latency: done=%b want 1", tag, done0);
            end
          end
        end
      end
    end
    k = 0;
    while (done0 !== 1'b1 && k < 2000) begin
      @(negedge clk); k++;
    end
    n_vec++;
    if (done0 !== 1'b1 || busy0 !== 1'b0 || pass0 !== (exp_err == 0) ||
        err0 !== 6'(exp_err) || wc0 !== 6'd16) begin
      n_bad++;
      $display("FAIL %s result: done=%b busy=%b pass=%b err=%0d wc=%0d want 1/0/%b/%0d/16",
               tag, done0, busy0, pass0, err0, wc0, (exp_err == 0), exp_err);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start0 = 1'b1; rxv0 = 1'b1; rxd0 = 8'hA5;
    repeat (3) @(negedge clk);
    n_vec++;
    if (txv0 !== 1'b0 || txd0 !== 8'h00 || busy0 !== 1'b0 || done0 !== 1'b0 ||
        pass0 !== 1'b0 || err0 !== 6'd0 || wc0 !== 6'd0) begin
      n_bad++;
      $display("FAIL reset_dut0: v=%b d=%h b=%b dn=%b p=%b e=%0d w=%0d want all 0",
               txv0, txd0, busy0, done0, pass0, err0, wc0);
    end
    n_vec++;
    if (txv1 !== 1'b0 || busy1 !== 1'b0 || done1 !== 1'b0 || err1 !== 4'd0 ||
        txv2 !== 1'b0 || busy2 !== 1'b0 || done2 !== 1'b0 || err2 !== 4'd0) begin
      n_bad++;
      $display("FAIL reset_dut12: v1=%b b1=%b d1=%b e1=%0d v2=%b b2=%b d2=%b e2=%0d want all 0",
               txv1, busy1, done1, err1, txv2, busy2, done2, err2);
    end
    rst = 1'b0; start0 = 1'b0;
    @(negedge clk); rxv0 = 1'b0;
    @(negedge clk);
    n_vec++;
    if (err0 !== 6'd0 || busy0 !== 1'b0) begin
      n_bad++;
      $display("FAIL stray_idle: err=%0d busy=%b want 0/0", err0, busy0);
    end
  endtask

  task automatic test_ideal();
    clear_plan();
    run0("ideal", 1'b0);
    @(negedge clk); rxv0 = 1'b1; rxd0 = 8'h00;
    @(negedge clk); rxv0 = 1'b0;
    @(negedge clk);
    n_vec++;
    if (err0 !== 6'd0 || done0 !== 1'b1 || pass0 !== 1'b1) begin
      n_bad++;
      $display("FAIL stray_done: err=%0d done=%b pass=%b want 0/1/1", err0, done0, pass0);
    end
  endtask

  task automatic test_bad_word();
    clear_plan();
    bad_q[5] = 1'b1;
    badv_q[5] = 8'h00;
    run0("bad_word5", 1'b0);
  endtask

  task automatic test_ready_stall();
    clear_plan();
    stall_q[0] = 20;
    run0("ready_stall", 1'b0);
  endtask

  task automatic test_stray_wait();
    clear_plan();
    run0("stray_wait", 1'b1);
  endtask

  task automatic test_start_busy();
    clear_plan();
    for (int i = 0; i < 16; i += 3) begin
      stall_q[i] = 2;
      sb_q[i] = 1'b1;
    end
    run0("start_busy", 1'b0);
  endtask

  task automatic test_reset_mid();
    int k;
    @(negedge clk); start0 = 1'b1;
    @(negedge clk); start0 = 1'b0;
    rxv0 = 1'b1; rxd0 = 8'h5A;
    @(negedge clk); rxv0 = 1'b0;
    k = 0;
    while (txv0 !== 1'b1 && k < 40) begin
      @(negedge clk); k++;
    end
    ready0 = 1'b1;
    @(negedge clk); ready0 = 1'b0;
    @(negedge clk);
    n_vec++;
    if (err0 !== 6'd1 || busy0 !== 1'b1 || txd0 !== 8'h41) begin
      n_bad++;
      $display("FAIL pre_reset: err=%0d busy=%b data=%h want 1/1/41", err0, busy0, txd0);
    end
    rst = 1'b1; start0 = 1'b1;
    @(negedge clk); rst = 1'b0; start0 = 1'b0;
    n_vec++;
    if (txv0 !== 1'b0 || txd0 !== 8'h00 || busy0 !== 1'b0 || done0 !== 1'b0 ||
        pass0 !== 1'b0 || err0 !== 6'd0 || wc0 !== 6'd0) begin
      n_bad++;
      $display("FAIL reset_mid: v=%b d=%h b=%b dn=%b p=%b e=%0d w=%0d want all 0",
               txv0, txd0, busy0, done0, pass0, err0, wc0);
    end
    clear_plan();
    run0("rerun", 1'b0);
  endtask

  task automatic test_timeout(input bit hit_expiry);
    int k;
    int exp_err;
    logic [7:0] pat;
    exp_err = hit_expiry ? 2 : 3;
    @(negedge clk); start1 = 1'b1;
    @(negedge clk); start1 = 1'b0;
    k = 1;
    n_vec++;
    if (done1 !== 1'b0 || busy1 !== 1'b1) begin
      n_bad++;
      $display("FAIL timeout start_ack: done=%b busy=%b want 0/1", done1, busy1);
    end
    while (txv1 !== 1'b1 && k < 40) begin
      @(negedge clk); k++;
    end
    n_vec++;
    if (k !== 3) begin
      n_bad++;
      $display("FAIL timeout first_valid_latency: got %0d want 3", k);
    end
    for (int i = 0; i < 3; i++) begin
      pat = 8'(8'hFE + i);
      k = 0;
      while (txv1 !== 1'b1 && k < 40) begin
        @(negedge clk); k++;
      end
      n_vec++;
      if (txd1 !== pat || txv1 !== 1'b1) begin
        n_bad++;
        $display("FAIL timeout tx_data word %0d: valid=%b data=%h want 1/%h", i, txv1, txd1, pat);
      end
      @(negedge clk);
      if (hit_expiry && i == 2) begin
        repeat (6) @(negedge clk);
        n_vec++;
        if (busy1 !== 1'b1 || done1 !== 1'b0) begin
          n_bad++;
          $display("FAIL expiry_early: busy=%b done=%b want 1/0", busy1, done1);
        end
        rxv1 = 1'b1; rxd1 = pat;
        @(negedge clk); rxv1 = 1'b0;
        n_vec++;
        if (done1 !== 1'b1) begin
          n_bad++;
          $display("FAIL expiry_retire: done=%b want 1", done1);
        end
      end else begin
        k = 0;
        while (txv1 !== 1'b1 && done1 !== 1'b1 && k < 40) begin
          @(negedge clk); k++;
        end
        n_vec++;
        if (k !== 7) begin
          n_bad++;
          $display("FAIL timeout_len word %0d: got %0d cycles want 7", i, k);
        end
      end
    end
    n_vec++;
    if (done1 !== 1'b1 || pass1 !== 1'b0 || err1 !== 4'(exp_err) || wc1 !== 4'd3) begin
      n_bad++;
      $display("FAIL timeout result: done=%b pass=%b err=%0d wc=%0d want 1/0/%0d/3",
               done1, pass1, err1, wc1, exp_err);
    end
  endtask

  task automatic test_rotate();
    int k;
    logic [7:0] pat;
    pat = 8'h81;
    @(negedge clk); start2 = 1'b1;
    @(negedge clk); start2 = 1'b0;
    n_vec++;
    if (txv2 !== 1'b1) begin
      n_bad++;
      $display("FAIL rotate first_valid_latency: valid=%b want 1", txv2);
    end
    for (int i = 0; i < 3; i++) begin
      k = 0;
      while (txv2 !== 1'b1 && k < 40) begin
        @(negedge clk); k++;
      end
      n_vec++;
      if (txd2 !== pat || txv2 !== 1'b1) begin
        n_bad++;
        $display("FAIL rotate tx_data word %0d: valid=%b data=%h want 1/%h", i, txv2, txd2, pat);
      end
      @(negedge clk);
      pat = 8'((pat << 1) | (pat >> 7));
    end
    k = 0;
    while (done2 !== 1'b1 && k < 40) begin
      @(negedge clk); k++;
    end
    n_vec++;
    if (done2 !== 1'b1 || err2 !== 4'd3 || wc2 !== 4'd3 || pass2 !== 1'b0) begin
      n_bad++;
      $display("FAIL rotate result: done=%b err=%0d wc=%0d pass=%b want 1/3/3/0", done2, err2, wc2, pass2);
    end
  endtask

  task automatic test_random();
    for (int r = 0; r < 3; r++) begin
      clear_plan();
      for (int i = 0; i < 16; i++) begin
        stall_q[i] = $urandom_range(0, 3);
        dly_q[i]   = $urandom_range(1, 6);
        bad_q[i]   = ($urandom_range(0, 4) == 0);
        badv_q[i]  = 8'(8'h41 + i) ^ 8'($urandom_range(1, 255));
        sb_q[i]    = (stall_q[i] > 0) && ($urandom_range(0, 3) == 0);
      end
      if (r == 1) drop_q[$urandom_range(0, 15)] = 1'b1;
      run0($sformatf("random%0d", r), 1'b0);
    end
  endtask

  initial begin
    test_reset();
    test_ideal();
    test_bad_word();
    test_ready_stall();
    test_stray_wait();
    test_start_busy();
    test_reset_mid();
    test_timeout(1'b0);
    test_timeout(1'b1);
    test_rotate();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
